shift_pipe: RTL and testbench
=============================

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values are powers of two, 8..64.
REQ-002 SHALL have parameter AMT_W, default 8, register shift-amount width; legal values are >= log2(WIDTH)+1.
REQ-003 SHALL have parameter TAG_W, default 4, sideband tag width.
REQ-004 SHALL define derived SH_W = log2(WIDTH), the immediate-amount width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-009 in_data  in  WIDTH  operand (Rm value).
REQ-010 in_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-011 in_reg  in  1  0 amount from in_imm, 1 amount from in_rs.
REQ-012 in_imm  in  SH_W  immediate amount.
REQ-013 in_rs  in  AMT_W  register amount (low bits of Rs).
REQ-014 in_cin  in  1  current C flag.
REQ-015 in_bypass  in  1  pass operand unshifted; cout = in_cin.
REQ-016 in_tag  in  TAG_W  carried unchanged to out_tag.
REQ-017 out_valid  out  1  result present.
REQ-018 out_ready  in  1  result consumed when out_valid && out_ready.
REQ-019 out_data  out  WIDTH  shifted result.
REQ-020 out_cout  out  1  shifter carry-out.
REQ-021 out_tag  out  TAG_W  tag of the result.

Function
REQ-022 Two-stage pipeline: S1 captures the accepted request, resolves amount and special cases, and applies the coarse shift (amount bits >= SH_W/2); S2 applies the fine shift and computes carry.
REQ-023 Latency SHALL be exactly 2 cycles from acceptance to out_valid when no backpressure; throughput 1 per cycle.
REQ-024 S2 SHALL load when S2 is empty or out_ready=1; S1 SHALL load when S1 is empty or S1 advances; in_ready = !S1_valid || S1 advances (combinational from out_ready is permitted).
REQ-025 While out_valid=1 and out_ready=0, out_data, out_cout and out_tag SHALL hold stable.
REQ-026 Results SHALL emerge in acceptance order with no loss or duplication; in_cin SHALL be sampled at acceptance.
REQ-027 Immediate, amount 0: LSL passes the operand with cout=cin; LSR and ASR act as amount WIDTH; ROR acts as RRX: {cin, x[W-1:1]}, cout=x[0].
REQ-028 Register (or immediate) amount n=0: pass the operand, cout=cin, for all ops.
REQ-029 LSL: 0<n<W gives x<<n, cout=x[W-n]; n=W gives 0, cout=x[0]; n>W gives 0, cout=0.
REQ-030 LSR: 0<n<W gives x>>n, cout=x[n-1]; n=W gives 0, cout=x[W-1]; n>W gives 0, cout=0.
REQ-031 ASR: 0<n<W gives arithmetic shift, cout=x[n-1]; n>=W gives all bits = x[W-1], cout=x[W-1].
REQ-032 ROR register: n!=0 and n mod W=0 gives x, cout=x[W-1]; otherwise rotate right by n mod W, cout=x[(n mod W)-1].
REQ-033 in_bypass=1 SHALL override in_op/amount decode and traverse the pipeline with identical latency.

Reset
REQ-034 reset_n=0 SHALL immediately clear S1_valid, S2_valid, out_valid, out_data, out_cout and out_tag to 0 and discard in-flight requests.
REQ-035 in_ready SHALL be 1 during reset and in the first cycle after release.
REQ-036 No request SHALL be accepted while reset_n=0.

Verification (WIDTH=32)
REQ-037 LSL imm 4, x=0x8000000F -> 0x000000F0, cout=0, out_valid 2 cycles after accept.
REQ-038 LSR imm 0, x=0x80000001 -> 0x00000000, cout=1; ASR reg rs=0x40, x=0x80000000 -> 0xFFFFFFFF, cout=1.
REQ-039 ROR imm 0 (RRX) with cin=1, x=0x00000003 -> 0x80000001, cout=1; ROR reg rs=0x24, x=0x0000000F -> 0xF0000000, cout=1; rs=0x20, x=0x80000001 -> 0x80000001, cout=1.
REQ-040 LSL reg rs=0x20, x=0x00000001 -> 0, cout=1; rs=0x21 -> 0, cout=0; rs=0 with cin=1 -> x, cout=1.
REQ-041 Back-to-back tags 1,2,3 with out_ready=0 from the first out_valid: in_ready drops after 2 are held; tag 1 output stays stable; after out_ready=1, tags 1,2,3 emerge in order on consecutive cycles.
REQ-042 Assert reset_n=0 with 2 requests in flight: out_valid=0 in the same cycle; after release no stale result appears and a new request completes in 2 cycles.

Source files
------------

// File: rtl/shift_pipe.sv
// Barrel shifter (LSL/LSR/ASR/ROR with ARM-style carry), two register stages: coarse shift then fine shift.
// Latency 2 cycles, 1/cycle throughput; out_ready=0 holds the result and stalls S1 once it is full.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8,
  parameter int TAG_W = 4,
  localparam int SH_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_reg,
  input  logic [SH_W-1:0]  in_imm,
  input  logic [AMT_W-1:0] in_rs,
  input  logic             in_cin,
  input  logic             in_bypass,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int FW = SH_W / 2;
  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // ext carries one guard bit so the carry falls out of the same shift:
  // left shifts keep it at ext[WIDTH], right shifts at ext[0].
  typedef struct packed {
    logic [1:0]       mode;
    logic [WIDTH:0]   ext;
    logic [FW-1:0]    fine;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic             s1_vld_q, s1_vld_d;
  s1_t              s1_q, s1_d, s1_new;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_cout_q, out_cout_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             s2_load, s1_adv, accept;
  logic [AMT_W-1:0] amt;
  logic [SH_W-1:0]  sh, coarse;
  logic             special, sp_c;
  logic [WIDTH-1:0] sp_res;
  logic [WIDTH:0]   e_l, e_r, e_a;
  logic [WIDTH-1:0] rot_f, res;
  logic             res_c;

  assign s2_load  = !s2_vld_q || out_ready;
  assign s1_adv   = s1_vld_q && s2_load;
  assign in_ready = !s1_vld_q || s2_load;
  assign accept   = in_valid && in_ready;

  // Stage 1: amount resolution, special cases, coarse shift
  always_comb begin
    amt     = in_reg ? in_rs : AMT_W'(in_imm);
    sh      = amt[SH_W-1:0];
    coarse  = {sh[SH_W-1:FW], {FW{1'b0}}};
    special = 1'b0;
    sp_res  = in_data;
    sp_c    = in_cin;
    if (in_bypass || (amt == '0 && (in_reg || in_op == OP_LSL))) begin
      special = 1'b1;
    end else if (!in_reg && in_imm == '0) begin
      // Immediate zero encodes shift-by-WIDTH for LSR/ASR and RRX for ROR
      special = 1'b1;
      case (in_op)
        OP_LSR: begin
          sp_res = '0;
          sp_c   = in_data[WIDTH-1];
        end
        OP_ASR: begin
          sp_res = {WIDTH{in_data[WIDTH-1]}};
          sp_c   = in_data[WIDTH-1];
        end
        default: begin
          sp_res = {in_cin, in_data[WIDTH-1:1]};
          sp_c   = in_data[0];
        end
      endcase
    end else if (in_op != OP_ROR && amt >= AMT_W'(WIDTH)) begin
      special = 1'b1;
      case (in_op)
        OP_LSL: begin
          sp_res = '0;
          sp_c   = (amt == AMT_W'(WIDTH)) && in_data[0];
        end
        OP_LSR: begin
          sp_res = '0;
          sp_c   = (amt == AMT_W'(WIDTH)) && in_data[WIDTH-1];
        end
        default: begin
          sp_res = {WIDTH{in_data[WIDTH-1]}};
          sp_c   = in_data[WIDTH-1];
        end
      endcase
    end

    s1_new.tag  = in_tag;
    s1_new.mode = in_op;
    s1_new.fine = sh[FW-1:0];
    case (in_op)
      OP_LSL:  s1_new.ext = {1'b0, in_data} << coarse;
      OP_LSR:  s1_new.ext = {in_data, 1'b0} >> coarse;
      OP_ASR:  s1_new.ext = $unsigned($signed({in_data, 1'b0}) >>> coarse);
      default: s1_new.ext = {1'b0, (in_data >> coarse) | (in_data << (WIDTH - int'(coarse)))};
    endcase
    // Special results ride through as a zero-length right shift of {result, carry}
    if (special) begin
      s1_new.mode = OP_LSR;
      s1_new.ext  = {sp_res, sp_c};
      s1_new.fine = '0;
    end

    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_d     = s1_new;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end
  end

  // Stage 2: fine shift and carry extraction
  always_comb begin
    e_l   = s1_q.ext << s1_q.fine;
    e_r   = s1_q.ext >> s1_q.fine;
    e_a   = $unsigned($signed(s1_q.ext) >>> s1_q.fine);
    rot_f = (s1_q.ext[WIDTH-1:0] >> s1_q.fine)
          | (s1_q.ext[WIDTH-1:0] << (WIDTH - int'(s1_q.fine)));
    case (s1_q.mode)
      OP_LSL: begin
        res   = e_l[WIDTH-1:0];
        res_c = e_l[WIDTH];
      end
      OP_LSR: begin
        res   = e_r[WIDTH:1];
        res_c = e_r[0];
      end
      OP_ASR: begin
        res   = e_a[WIDTH:1];
        res_c = e_a[0];
      end
      default: begin
        res   = rot_f;
        res_c = rot_f[WIDTH-1];
      end
    endcase

    s2_vld_d   = s2_load ? s1_vld_q : s2_vld_q;
    out_data_d = out_data_q;
    out_cout_d = out_cout_q;
    out_tag_d  = out_tag_q;
    if (s1_adv) begin
      out_data_d = res;
      out_cout_d = res_c;
      out_tag_d  = s1_q.tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q   <= 1'b0;
      s1_q       <= '0;
      s2_vld_q   <= 1'b0;
      out_data_q <= '0;
      out_cout_q <= 1'b0;
      out_tag_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_q       <= s1_d;
      s2_vld_q   <= s2_vld_d;
      out_data_q <= out_data_d;
      out_cout_q <= out_cout_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_data  = out_data_q;
  assign out_cout  = out_cout_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe (WIDTH=32): shift/carry corner cases, latency,
// backpressure ordering and mid-flight reset, all against hand-computed values.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic        in_reg;
  logic [4:0]  in_imm;
  logic [7:0]  in_rs;
  logic        in_cin, in_bypass;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_cout;
  logic [3:0]  out_tag;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_pipe dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .in_reg(in_reg), .in_imm(in_imm), .in_rs(in_rs), .in_cin(in_cin),
    .in_bypass(in_bypass), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cout(out_cout), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic rg, input logic [4:0] imm,
                       input logic [7:0] rs, input logic cin, input logic byp,
                       input logic [31:0] x, input logic [3:0] tag);
    in_op = op; in_reg = rg; in_imm = imm; in_rs = rs;
    in_cin = cin; in_bypass = byp; in_data = x; in_tag = tag;
  endtask

  // One isolated transaction: accepted at the first edge, result after the second
  task automatic send(input string nm, input logic [1:0] op, input logic rg,
                      input logic [4:0] imm, input logic [7:0] rs, input logic cin,
                      input logic byp, input logic [31:0] x, input logic [3:0] tag,
                      input logic [31:0] exp_d, input logic exp_c);
    drive(op, rg, imm, rs, cin, byp, x, tag);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({nm, ".in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({nm, ".early_valid"}, out_valid, 0);
    tick();
    check({nm, ".valid"}, out_valid, 1);
    check({nm, ".data"}, out_data, exp_d);
    check({nm, ".cout"}, out_cout, exp_c);
    check({nm, ".tag"}, out_tag, tag);
    tick();
    check({nm, ".drained"}, out_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'b00, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_data", out_data, 0);
    check("rst.out_tag", out_tag, 0);

    // Request held during reset must not be accepted
    drive(2'b00, 1'b0, 5'd4, 8'd0, 1'b1, 1'b0, 32'hDEADBEEF, 4'd9);
    in_valid = 1'b1;
    tick(); tick();
    check("rst.hold_ready", in_ready, 1);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    check("rst.no_accept1", out_valid, 0);
    tick();
    check("rst.no_accept2", out_valid, 0);

    //    name        op     reg  imm    rs     cin  byp  x             tag   exp_d          c
    send("lsl_imm4",  2'b00, 0, 5'd4,  8'h00, 0, 0, 32'h8000000F, 4'd1, 32'h000000F0, 0);
    send("lsr_imm0",  2'b01, 0, 5'd0,  8'h00, 0, 0, 32'h80000001, 4'd2, 32'h00000000, 1);
    send("asr_rs40",  2'b10, 1, 5'd0,  8'h40, 0, 0, 32'h80000000, 4'd3, 32'hFFFFFFFF, 1);
    send("rrx",       2'b11, 0, 5'd0,  8'h00, 1, 0, 32'h00000003, 4'd4, 32'h80000001, 1);
    send("ror_rs24",  2'b11, 1, 5'd0,  8'h24, 0, 0, 32'h0000000F, 4'd5, 32'hF0000000, 1);
    send("ror_rs20",  2'b11, 1, 5'd0,  8'h20, 0, 0, 32'h80000001, 4'd6, 32'h80000001, 1);
    send("lsl_rs20",  2'b00, 1, 5'd0,  8'h20, 0, 0, 32'h00000001, 4'd7, 32'h00000000, 1);
    send("lsl_rs21",  2'b00, 1, 5'd0,  8'h21, 0, 0, 32'h00000001, 4'd8, 32'h00000000, 0);
    send("lsl_rs0",   2'b00, 1, 5'd0,  8'h00, 1, 0, 32'h00000001, 4'd9, 32'h00000001, 1);
    send("lsr_rs5",   2'b01, 1, 5'd0,  8'h05, 0, 0, 32'h000000F0, 4'd10, 32'h00000007, 1);
    send("asr_rs7",   2'b10, 1, 5'd0,  8'h07, 1, 0, 32'h80000000, 4'd11, 32'hFF000000, 0);
    send("ror_imm3",  2'b11, 0, 5'd3,  8'h00, 0, 0, 32'h00000005, 4'd12, 32'hA0000000, 1);
    send("lsl_imm31", 2'b00, 0, 5'd31, 8'h00, 0, 0, 32'h00000003, 4'd13, 32'h80000000, 1);
    send("lsr_rs20",  2'b01, 1, 5'd0,  8'h20, 0, 0, 32'h80000000, 4'd14, 32'h00000000, 1);
    send("asr_imm0",  2'b10, 0, 5'd0,  8'h00, 1, 0, 32'h7FFFFFFF, 4'd15, 32'h00000000, 0);
    send("bypass",    2'b00, 0, 5'd4,  8'h00, 0, 1, 32'h12345678, 4'd0, 32'h12345678, 0);
    send("ror_rs0",   2'b11, 1, 5'd0,  8'h00, 1, 0, 32'h00000006, 4'd3, 32'h00000006, 1);

    // Streaming: three LSL #1 requests on consecutive cycles
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(2'b00, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0, 32'd10, 4'd1);
    tick();
    drive(2'b00, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0, 32'd20, 4'd2);
    tick();
    check("stream.a_data", out_data, 32'd20);
    check("stream.a_valid", out_valid, 1);
    drive(2'b00, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0, 32'd30, 4'd3);
    check("stream.ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("stream.b_data", out_data, 32'd40);
    tick();
    check("stream.c_data", out_data, 32'd60);
    check("stream.c_tag", out_tag, 3);
    tick();
    check("stream.drained", out_valid, 0);

    // Backpressure: out_ready low from first out_valid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(2'b00, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0, 32'd1, 4'd1);
    check("bp.rdy1", in_ready, 1);
    tick();
    drive(2'b00, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0, 32'd2, 4'd2);
    check("bp.rdy2", in_ready, 1);
    tick();
    drive(2'b00, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0, 32'd3, 4'd3);
    check("bp.rdy3_low", in_ready, 0);
    check("bp.valid", out_valid, 1);
    check("bp.tag1", out_tag, 1);
    check("bp.data1", out_data, 32'd2);
    tick();
    check("bp.tag1_hold", out_tag, 1);
    check("bp.data1_hold", out_data, 32'd2);
    check("bp.valid_hold", out_valid, 1);
    check("bp.rdy_still_low", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp.rdy_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp.tag2", out_tag, 2);
    check("bp.data2", out_data, 32'd4);
    tick();
    check("bp.tag3", out_tag, 3);
    check("bp.valid3", out_valid, 1);
    tick();
    check("bp.drained", out_valid, 0);

    // Reset with two requests in flight
    in_valid = 1'b1;
    drive(2'b11, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 32'h00000003, 4'd5);
    tick();
    drive(2'b00, 1'b0, 5'd4, 8'd0, 1'b0, 1'b0, 32'h0000000F, 4'd6);
    tick();
    in_valid = 1'b0;
    check("inflight.valid", out_valid, 1);
    check("inflight.data", out_data, 32'h80000001);
    reset_n = 1'b0;
    #1;
    check("midrst.valid", out_valid, 0);
    check("midrst.data", out_data, 0);
    check("midrst.cout", out_cout, 0);
    check("midrst.tag", out_tag, 0);
    check("midrst.ready", in_ready, 1);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("postrst.no_stale", out_valid, 0);
      if (i < 2) tick();
    end
    send("postrst", 2'b01, 1, 5'd0, 8'h04, 0, 0, 32'h000000F0, 4'd7, 32'h0000000F, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
